// File: rtl/beta_pkg.sv
// Shared opcodes, PCSEL/WDSEL encodings and the control bundle for the Beta control unit.
package beta_pkg;

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_JMP = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011100;
  localparam logic [5:0] OP_BNE = 6'b011101;
  localparam logic [5:0] OP_LDR = 6'b011111;

  localparam logic [2:0] PC_INC   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_JMP   = 3'd2;
  localparam logic [2:0] PC_ILLOP = 3'd3;
  localparam logic [2:0] PC_XADR  = 3'd4;

  localparam logic [1:0] WD_PC  = 2'd0;
  localparam logic [1:0] WD_ALU = 2'd1;
  localparam logic [1:0] WD_MEM = 2'd2;

  // is_beq/is_bne let the top resolve PCSEL against Z outside the pure opcode decode.
  typedef struct packed {
    logic [5:0] alufn;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic [2:0] pcsel;
    logic       ra2sel;
    logic       wasel;
    logic [1:0] wdsel;
    logic       werf;
    logic       is_beq;
    logic       is_bne;
  } ctrl_t;

  function automatic ctrl_t illop_ctrl();
    ctrl_t c;
    c       = '0;
    c.pcsel = PC_ILLOP;
    c.wasel = 1'b1;
    c.wdsel = WD_PC;
    c.werf  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/beta_opcode_decode.sv
// Combinational opcode -> control bundle decode for the Beta.
// BETA_MULDIV_EN: when defined, MUL/DIV opcodes decode as ALU ops instead of ILLOP.
module beta_opcode_decode
  import beta_pkg::*;
#(
  parameter logic [5:0] LDST_ALUFN = 6'b100000,
  parameter logic [5:0] LDR_ALUFN  = 6'b111111
) (
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  logic nib_ok;
  logic muldiv;
  logic alu_ok;

  // Low nibbles x111 are unassigned in both OP and OPC groups.
  assign nib_ok = (op[2:0] != 3'b111);
  assign muldiv = (op[3:1] == 3'b001);

`ifdef BETA_MULDIV_EN
  assign alu_ok = nib_ok;
`else
  assign alu_ok = nib_ok & ~muldiv;
`endif

  always_comb begin
    ctrl = illop_ctrl();
    if (op[5]) begin
      if (alu_ok) begin
        ctrl       = '0;
        ctrl.alufn = op;
        ctrl.bsel  = op[4];
        ctrl.wdsel = WD_ALU;
        ctrl.werf  = 1'b1;
      end
    end else begin
      case (op)
        OP_LD: begin
          ctrl       = '0;
          ctrl.alufn = LDST_ALUFN;
          ctrl.bsel  = 1'b1;
          ctrl.moe   = 1'b1;
          ctrl.wdsel = WD_MEM;
          ctrl.werf  = 1'b1;
        end
        OP_ST: begin
          ctrl        = '0;
          ctrl.alufn  = LDST_ALUFN;
          ctrl.bsel   = 1'b1;
          ctrl.ra2sel = 1'b1;
          ctrl.mwr    = 1'b1;
        end
        OP_JMP: begin
          ctrl       = '0;
          ctrl.pcsel = PC_JMP;
          ctrl.wdsel = WD_PC;
          ctrl.werf  = 1'b1;
        end
        OP_BEQ: begin
          ctrl        = '0;
          ctrl.wdsel  = WD_PC;
          ctrl.werf   = 1'b1;
          ctrl.is_beq = 1'b1;
        end
        OP_BNE: begin
          ctrl        = '0;
          ctrl.wdsel  = WD_PC;
          ctrl.werf   = 1'b1;
          ctrl.is_bne = 1'b1;
        end
        OP_LDR: begin
          ctrl       = '0;
          ctrl.alufn = LDR_ALUFN;
          ctrl.asel  = 1'b1;
          ctrl.moe   = 1'b1;
          ctrl.wdsel = WD_MEM;
          ctrl.werf  = 1'b1;
        end
        default: ctrl = illop_ctrl();
      endcase
    end
  end

endmodule

// File: rtl/beta_ctrl_unit.sv
// Beta control unit: opcode decode plus reset override, interrupt-pending latch and branch resolve.
// BETA_MULDIV_EN (see beta_opcode_decode) enables MUL/DIV decode.
module beta_ctrl_unit
  import beta_pkg::*;
#(
  parameter logic [5:0] LDST_ALUFN = 6'b100000,
  parameter logic [5:0] LDR_ALUFN  = 6'b111111
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        IRQ,
  input  logic        SUP,
  input  logic        Z,
  input  logic [31:0] instruction,
  output logic [5:0]  ALUFN,
  output logic        ASEL,
  output logic        BSEL,
  output logic        MOE,
  output logic        MWR,
  output logic [2:0]  PCSEL,
  output logic        RA2SEL,
  output logic        WASEL,
  output logic [1:0]  WDSEL,
  output logic        WERF
);

  ctrl_t dec;
  ctrl_t ctl;
  logic  irq_pend;
  logic  take;
  logic  unused_bits;

  beta_opcode_decode #(
    .LDST_ALUFN(LDST_ALUFN),
    .LDR_ALUFN (LDR_ALUFN)
  ) u_decode (
    .op  (instruction[31:26]),
    .ctrl(dec)
  );

  assign take = irq_pend & ~SUP;

  // A new request outranks the clear, so a still-asserted IRQ keeps the latch set.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_pend <= 1'b0;
    end else if (IRQ) begin
      irq_pend <= 1'b1;
    end else if (take) begin
      irq_pend <= 1'b0;
    end
  end

  always_comb begin
    ctl = dec;
    if (dec.is_beq) ctl.pcsel = Z ? PC_BR : PC_INC;
    if (dec.is_bne) ctl.pcsel = Z ? PC_INC : PC_BR;
    if (take) begin
      ctl       = '0;
      ctl.pcsel = PC_XADR;
      ctl.wasel = 1'b1;
      ctl.wdsel = WD_PC;
      ctl.werf  = 1'b1;
    end
    if (!RESET_N) ctl = '0;
  end

  assign ALUFN  = ctl.alufn;
  assign ASEL   = ctl.asel;
  assign BSEL   = ctl.bsel;
  assign MOE    = ctl.moe;
  assign MWR    = ctl.mwr;
  assign PCSEL  = ctl.pcsel;
  assign RA2SEL = ctl.ra2sel;
  assign WASEL  = ctl.wasel;
  assign WDSEL  = ctl.wdsel;
  assign WERF   = ctl.werf;

  assign unused_bits = ^{instruction[25:0], ctl.is_beq, ctl.is_bne};

endmodule

// File: tb/tb_beta_ctrl_unit.sv
// Directed bench for beta_ctrl_unit: decode vector table plus interrupt and reset sequences.
module tb_beta_ctrl_unit;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        IRQ;
  logic        SUP;
  logic        Z;
  logic [31:0] instruction;
  logic [5:0]  ALUFN;
  logic        ASEL;
  logic        BSEL;
  logic        MOE;
  logic        MWR;
  logic [2:0]  PCSEL;
  logic        RA2SEL;
  logic        WASEL;
  logic [1:0]  WDSEL;
  logic        WERF;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [5:0]   op;
    logic         z;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  beta_ctrl_unit dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .IRQ        (IRQ),
    .SUP        (SUP),
    .Z          (Z),
    .instruction(instruction),
    .ALUFN      (ALUFN),
    .ASEL       (ASEL),
    .BSEL       (BSEL),
    .MOE        (MOE),
    .MWR        (MWR),
    .PCSEL      (PCSEL),
    .RA2SEL     (RA2SEL),
    .WASEL      (WASEL),
    .WDSEL      (WDSEL),
    .WERF       (WERF)
  );

  function automatic logic [W-1:0] mk(input logic [5:0] alufn, input logic asel, input logic bsel,
                                      input logic moe, input logic mwr, input logic [2:0] pcsel,
                                      input logic ra2sel, input logic wasel, input logic [1:0] wdsel,
                                      input logic werf);
    return {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [5:0] op);
    instruction = {op, 26'($urandom)};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    logic [W-1:0] want;
    exp_q.push_back(exp);
    act  = {ALUFN, ASEL, BSEL, MOE, MWR, PCSEL, RA2SEL, WASEL, WDSEL, WERF};
    want = exp_q.pop_front();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (ALUFN asel bsel moe mwr PCSEL ra2 wa WDSEL werf)",
               name, act, want);
    end
  endtask

  logic [W-1:0] e_add, e_ld, e_st, e_ill, e_xadr;

  initial begin
    e_add  = mk(6'h20, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1);
    e_ld   = mk(6'h20, 0, 1, 1, 0, 3'd0, 0, 0, 2'd2, 1);
    e_st   = mk(6'h20, 0, 1, 0, 1, 3'd0, 1, 0, 2'd0, 0);
    e_ill  = mk(6'h00, 0, 0, 0, 0, 3'd3, 0, 1, 2'd0, 1);
    e_xadr = mk(6'h00, 0, 0, 0, 0, 3'd4, 0, 1, 2'd0, 1);

    vecs.push_back('{6'b100000, 1'b0, e_add});
    vecs.push_back('{6'b110001, 1'b0, mk(6'h31, 0, 1, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
    vecs.push_back('{6'b011000, 1'b0, e_ld});
    vecs.push_back('{6'b011001, 1'b0, e_st});
    vecs.push_back('{6'b011100, 1'b1, mk(6'h00, 0, 0, 0, 0, 3'd1, 0, 0, 2'd0, 1)});
    vecs.push_back('{6'b011100, 1'b0, mk(6'h00, 0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 1)});
    vecs.push_back('{6'b011101, 1'b1, mk(6'h00, 0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 1)});
    vecs.push_back('{6'b011101, 1'b0, mk(6'h00, 0, 0, 0, 0, 3'd1, 0, 0, 2'd0, 1)});
    vecs.push_back('{6'b011011, 1'b0, mk(6'h00, 0, 0, 0, 0, 3'd2, 0, 0, 2'd0, 1)});
    vecs.push_back('{6'b000000, 1'b0, e_ill});
    vecs.push_back('{6'b100111, 1'b0, e_ill});
    vecs.push_back('{6'b011111, 1'b0, mk(6'h3F, 1, 0, 1, 0, 3'd0, 0, 0, 2'd2, 1)});
    vecs.push_back('{6'b011010, 1'b0, e_ill});
    vecs.push_back('{6'b011110, 1'b0, e_ill});
    vecs.push_back('{6'b111111, 1'b0, e_ill});
    vecs.push_back('{6'b001101, 1'b1, e_ill});
    vecs.push_back('{6'b101110, 1'b0, mk(6'h2E, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
    vecs.push_back('{6'b110110, 1'b1, mk(6'h36, 0, 1, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
    vecs.push_back('{6'b101000, 1'b0, mk(6'h28, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
`ifdef BETA_MULDIV_EN
    vecs.push_back('{6'b100010, 1'b0, mk(6'h22, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
    vecs.push_back('{6'b110011, 1'b0, mk(6'h33, 0, 1, 0, 0, 3'd0, 0, 0, 2'd1, 1)});
`else
    vecs.push_back('{6'b100010, 1'b0, e_ill});
    vecs.push_back('{6'b110011, 1'b0, e_ill});
`endif

    // Reset state, and a request during reset must not survive it.
    RESET_N = 1'b0;
    IRQ     = 1'b0;
    SUP     = 1'b0;
    Z       = 1'b0;
    set_op(6'b011000);
    #2 check("reset_outputs", '0);
    IRQ = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    IRQ     = 1'b0;
    RESET_N = 1'b1;
    #1 check("reset_release_ld", e_ld);
    @(negedge clk);
    #1 check("no_irq_after_reset", e_ld);

    // Decode table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      Z = vecs[i].z;
      set_op(vecs[i].op);
      #1 check($sformatf("vec%0d_op%b_z%0d", i, vecs[i].op, vecs[i].z), vecs[i].exp);
    end

    // Single-edge interrupt: taken next cycle, then back to decode.
    @(negedge clk);
    Z = 1'b0;
    set_op(6'b100000);
    IRQ = 1'b1;
    @(negedge clk);
    IRQ = 1'b0;
    #1 check("irq_take", e_xadr);
    @(negedge clk);
    #1 check("irq_back_to_decode", e_add);

    // Supervisor mode defers the interrupt without dropping it.
    @(negedge clk);
    SUP = 1'b1;
    IRQ = 1'b1;
    @(negedge clk);
    IRQ = 1'b0;
    #1 check("irq_masked_sup", e_add);
    @(negedge clk);
    #1 check("irq_held_sup", e_add);
    SUP = 1'b0;
    #1 check("irq_deferred_take", e_xadr);
    @(negedge clk);
    #1 check("irq_deferred_done", e_add);

    // Take and a still-asserted IRQ on the same edge: latch stays set.
    @(negedge clk);
    IRQ = 1'b1;
    @(negedge clk);
    #1 check("irq_level_take1", e_xadr);
    @(negedge clk);
    #1 check("irq_level_take2", e_xadr);
    IRQ = 1'b0;
    @(negedge clk);
    #1 check("irq_level_done", e_add);

    // Asynchronous reset mid-cycle during ST with an interrupt pending.
    @(negedge clk);
    set_op(6'b011001);
    SUP = 1'b1;
    IRQ = 1'b1;
    #1 check("st_before_reset", e_st);
    @(negedge clk);
    IRQ = 1'b0;
    #1 check("st_pending_masked", e_st);
    #2 RESET_N = 1'b0;
    #1 check("reset_async_zero", '0);
    @(posedge clk);
    @(negedge clk);
    #1 check("reset_held_zero", '0);
    RESET_N = 1'b1;
    SUP     = 1'b0;
    #1 check("pend_cleared_by_reset", e_st);
    @(negedge clk);
    #1 check("no_late_irq", e_st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
